fpu_add_seq: RTL and testbench

FPU_ADD_SEQ -- requirements
Module: fpu_add_seq

---
 rtl/fpu_add_seq_if.sv | 37 +++
 rtl/fpu_add_seq.sv | 105 ++++++++++
 tb/tb_fpu_add_seq.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpu_add_seq_if.sv
// Handshake and datapath-control bundle for the sequential FP add/sub controller.
// master = requesters/datapath side, slave = the controller.
interface fpu_add_seq_if;
    logic req0_valid;
    logic req1_valid;
    logic req0_sub;
    logic req1_sub;
    logic req0_ready;
    logic req1_ready;
    logic dp_sel;
    logic dp_sub;
    logic align_en;
    logic add_en;
    logic norm_en;
    logic round_en;
    logic dp_special;
    logic rsp_valid;
    logic rsp_ready;
    logic rsp_id;
    logic busy;

    modport master (
        output req0_valid, req1_valid, req0_sub, req1_sub,
        output dp_special, rsp_ready,
        input  req0_ready, req1_ready, dp_sel, dp_sub,
        input  align_en, add_en, norm_en, round_en,
        input  rsp_valid, rsp_id, busy
    );

    modport slave (
        input  req0_valid, req1_valid, req0_sub, req1_sub,
        input  dp_special, rsp_ready,
        output req0_ready, req1_ready, dp_sel, dp_sub,
        output align_en, add_en, norm_en, round_en,
        output rsp_valid, rsp_id, busy
    );
endinterface

// File: rtl/fpu_add_seq.sv
// Sequencing controller for a shared FP add/sub datapath with two
// round-robin requesters: ALIGN -> ADD -> NORM(xN) -> ROUND -> DONE.
module fpu_add_seq #(
    parameter int NORM_CYCLES = 2
) (
    input logic         clk,
    input logic         rst_n,
    fpu_add_seq_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE,
        ALIGN,
        ADD,
        NORM,
        ROUND,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [2:0] cnt;
    logic [2:0] cnt_nx;
    logic       last_grant;
    logic       sel_q;
    logic       sub_q;
    logic       any_valid;
    logic       grant;
    logic       window;
    logic       accept;
    logic       sub_in;

    // Reset gates the window so no ready leaks out while rst_n is low.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        grant     = (bus.req0_valid & bus.req1_valid) ? ~last_grant
                                                      : bus.req1_valid;
        window    = rst_n & ((state == IDLE) |
                             ((state == DONE) & bus.rsp_ready));
        accept    = window & any_valid;
        sub_in    = grant ? bus.req1_sub : bus.req0_sub;
    end

    assign bus.req0_ready = accept & ~grant;
    assign bus.req1_ready = accept & grant;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (accept) state_nx = ALIGN;
            end
            ALIGN: begin
                state_nx = bus.dp_special ? DONE : ADD;
            end
            ADD: begin
                state_nx = NORM;
                cnt_nx   = 3'(NORM_CYCLES - 1);
            end
            NORM: begin
                if (cnt == 3'd0) state_nx = ROUND;
                else             cnt_nx   = cnt - 3'd1;
            end
            ROUND: begin
                state_nx = DONE;
            end
            DONE: begin
                if (bus.rsp_ready) state_nx = accept ? ALIGN : IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            last_grant <= 1'b1;
            sel_q      <= 1'b0;
            sub_q      <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                last_grant <= grant;
                sel_q      <= grant;
                sub_q      <= sub_in;
            end
        end
    end

    assign bus.dp_sel    = sel_q;
    assign bus.dp_sub    = sub_q;
    assign bus.rsp_id    = sel_q;
    assign bus.align_en  = (state == ALIGN);
    assign bus.add_en    = (state == ADD);
    assign bus.norm_en   = (state == NORM);
    assign bus.round_en  = (state == ROUND);
    assign bus.rsp_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_fpu_add_seq.sv
// Directed bench for fpu_add_seq; three instances (NORM_CYCLES 2, 1, 8)
// share one stimulus set.
module tb_fpu_add_seq;

    logic clk = 1'b0;
    logic rst_n;
    logic r0v, r1v, r0s, r1s, spec, rrdy;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fpu_add_seq_if ifa ();
    fpu_add_seq_if ifb ();
    fpu_add_seq_if ifc ();

    assign ifa.req0_valid = r0v;
    assign ifa.req1_valid = r1v;
    assign ifa.req0_sub   = r0s;
    assign ifa.req1_sub   = r1s;
    assign ifa.dp_special = spec;
    assign ifa.rsp_ready  = rrdy;
    assign ifb.req0_valid = r0v;
    assign ifb.req1_valid = r1v;
    assign ifb.req0_sub   = r0s;
    assign ifb.req1_sub   = r1s;
    assign ifb.dp_special = spec;
    assign ifb.rsp_ready  = rrdy;
    assign ifc.req0_valid = r0v;
    assign ifc.req1_valid = r1v;
    assign ifc.req0_sub   = r0s;
    assign ifc.req1_sub   = r1s;
    assign ifc.dp_special = spec;
    assign ifc.rsp_ready  = rrdy;

    fpu_add_seq #(.NORM_CYCLES(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
    fpu_add_seq #(.NORM_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
    fpu_add_seq #(.NORM_CYCLES(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        rst_n = 1'b0;
        r0v = 1'b1; r1v = 1'b1; r0s = 1'b1; r1s = 1'b1;
        spec = 1'b0; rrdy = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        got = {ifa.req0_ready, ifa.req1_ready, ifa.align_en, ifa.add_en,
               ifa.norm_en, ifa.round_en, ifa.rsp_valid, ifa.rsp_id,
               ifa.busy, ifa.dp_sel};
        checks++;
        if (got !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected %b", got, 10'd0);
        end
        checks++;
        if (ifa.dp_sub !== 1'b0) begin
            errors++;
            $display("FAIL reset_dp_sub: got %b expected 0", ifa.dp_sub);
        end
        r0v = 1'b0; r1v = 1'b0; r0s = 1'b0; r1s = 1'b0;
        step();
        rst_n = 1'b1;
        #1;
        checks++;
        if (ifa.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: busy %b expected 0", ifa.busy);
        end
    endtask

    task automatic test_single_op();
        logic [4:0] tab [6];
        logic [4:0] got;
        tab = '{5'b10000, 5'b01000, 5'b00100, 5'b00100, 5'b00010, 5'b00001};
        step();
        r0v = 1'b1; r0s = 1'b0; r1v = 1'b0; rrdy = 1'b0; spec = 1'b0;
        #1;
        checks++;
        if (ifa.req0_ready !== 1'b1 || ifa.req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_accept: ready0 %b ready1 %b expected 1 0",
                     ifa.req0_ready, ifa.req1_ready);
        end
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 1) begin r0v = 1'b0; r0s = 1'b1; end
            if (k == 2) spec = 1'b1;
            if (k == 6) spec = 1'b0;
            #1;
            got = {ifa.align_en, ifa.add_en, ifa.norm_en,
                   ifa.round_en, ifa.rsp_valid};
            checks++;
            if (got !== tab[k-1]) begin
                errors++;
                $display("FAIL single_stage_T+%0d: got %b expected %b",
                         k, got, tab[k-1]);
            end
        end
        checks++;
        if ({ifa.rsp_id, ifa.dp_sel, ifa.dp_sub} !== 3'b000) begin
            errors++;
            $display("FAIL single_result: id/sel/sub %b%b%b expected 000",
                     ifa.rsp_id, ifa.dp_sel, ifa.dp_sub);
        end
        rrdy = 1'b1;
        step();
        #1;
        checks++;
        if (ifa.busy !== 1'b0) begin
            errors++;
            $display("FAIL single_to_idle: busy %b expected 0", ifa.busy);
        end
    endtask

    task automatic test_special();
        step();
        r1v = 1'b1; r1s = 1'b1; spec = 1'b1;
        #1;
        checks++;
        if (ifa.req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL special_accept: ready1 %b expected 1", ifa.req1_ready);
        end
        step();
        r1v = 1'b0; r1s = 1'b0;
        #1;
        checks++;
        if (ifa.align_en !== 1'b1) begin
            errors++;
            $display("FAIL special_align: align_en %b expected 1", ifa.align_en);
        end
        step();
        spec = 1'b0;
        #1;
        checks++;
        if ({ifa.rsp_valid, ifa.rsp_id, ifa.dp_sub} !== 3'b111) begin
            errors++;
            $display("FAIL special_done: valid/id/sub %b%b%b expected 111",
                     ifa.rsp_valid, ifa.rsp_id, ifa.dp_sub);
        end
        checks++;
        if ({ifa.add_en, ifa.norm_en, ifa.round_en} !== 3'b000) begin
            errors++;
            $display("FAIL special_no_stages: add/norm/round %b%b%b expected 000",
                     ifa.add_en, ifa.norm_en, ifa.round_en);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int n = 0;
        int last = 0;
        logic g;
        step();
        r0v = 1'b1; r1v = 1'b1; rrdy = 1'b1;
        for (int cyc = 0; cyc < 60 && n < 4; cyc++) begin
            #1;
            if (ifa.req0_ready || ifa.req1_ready) begin
                g = ifa.req1_ready;
                checks++;
                if (g !== 1'(n % 2)) begin
                    errors++;
                    $display("FAIL contention_grant%0d: got %b expected %0d",
                             n, g, n % 2);
                end
                if (n > 0) begin
                    checks++;
                    if (ifa.rsp_valid !== 1'b1 || cyc - last != 6) begin
                        errors++;
                        $display("FAIL contention_timing%0d: rsp_valid %b gap %0d expected 1 6",
                                 n, ifa.rsp_valid, cyc - last);
                    end
                end
                last = cyc;
                n++;
            end else if (n > 0) begin
                checks++;
                if (ifa.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL contention_bubble: busy %b expected 1", ifa.busy);
                end
            end
            if (n < 4) step();
        end
        checks++;
        if (n != 4) begin
            errors++;
            $display("FAIL contention_count: got %0d grants expected 4", n);
        end
        step();
        r0v = 1'b0; r1v = 1'b0; rrdy = 1'b0;
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 20 && !ifa.rsp_valid; i++) step();
        checks++;
        if (ifa.rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL bp_wait_done: rsp_valid %b expected 1", ifa.rsp_valid);
        end
        r1v = 1'b1; r1s = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({ifa.rsp_valid, ifa.rsp_id, ifa.req1_ready} !== 3'b110) begin
                errors++;
                $display("FAIL bp_hold%0d: valid/id/ready1 %b%b%b expected 110",
                         i, ifa.rsp_valid, ifa.rsp_id, ifa.req1_ready);
            end
            step();
        end
        rrdy = 1'b1;
        #1;
        checks++;
        if (ifa.req1_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_accept: ready1 %b expected 1", ifa.req1_ready);
        end
        step();
        r1v = 1'b0;
        #1;
        checks++;
        if ({ifa.align_en, ifa.rsp_valid, ifa.dp_sel} !== 3'b101) begin
            errors++;
            $display("FAIL bp_next_align: align/valid/sel %b%b%b expected 101",
                     ifa.align_en, ifa.rsp_valid, ifa.dp_sel);
        end
        for (int i = 0; i < 20 && ifa.busy; i++) step();
        checks++;
        if (ifa.busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_drain: busy %b expected 0", ifa.busy);
        end
    endtask

    task automatic test_reset_mid();
        step();
        r0v = 1'b1; rrdy = 1'b1;
        #1;
        step();
        r0v = 1'b0;
        for (int i = 0; i < 10 && !ifa.norm_en; i++) step();
        checks++;
        if (ifa.norm_en !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_reach_norm: norm_en %b expected 1", ifa.norm_en);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({ifa.busy, ifa.rsp_valid, ifa.norm_en} !== 3'b000) begin
            errors++;
            $display("FAIL rstmid_immediate: busy/valid/norm %b%b%b expected 000",
                     ifa.busy, ifa.rsp_valid, ifa.norm_en);
        end
        repeat (3) step();
        checks++;
        if (ifa.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_no_rsp: rsp_valid %b expected 0", ifa.rsp_valid);
        end
        r0v = 1'b1; r1v = 1'b1;
        rst_n = 1'b1;
        #1;
        checks++;
        if ({ifa.req0_ready, ifa.req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_first_grant: ready0/1 %b%b expected 10",
                     ifa.req0_ready, ifa.req1_ready);
        end
        step();
        r0v = 1'b0; r1v = 1'b0;
        #1;
        checks++;
        if ({ifa.align_en, ifa.dp_sel} !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_align_sel: align/sel %b%b expected 10",
                     ifa.align_en, ifa.dp_sel);
        end
        for (int i = 0; i < 20 && ifa.busy; i++) step();
    endtask

    task automatic test_param_sweep();
        int nb = 0, nc = 0, lb = 0, lc = 0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        rrdy = 1'b1; spec = 1'b0;
        step();
        r0v = 1'b1;
        #1;
        step();
        r0v = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            if (ifb.norm_en) nb++;
            if (ifc.norm_en) nc++;
            if (ifb.rsp_valid && lb == 0) lb = k;
            if (ifc.rsp_valid && lc == 0) lc = k;
            step();
        end
        checks++;
        if (nb != 1) begin
            errors++;
            $display("FAIL sweep_norm_width_1: got %0d expected 1", nb);
        end
        checks++;
        if (nc != 8) begin
            errors++;
            $display("FAIL sweep_norm_width_8: got %0d expected 8", nc);
        end
        checks++;
        if (lb != 5) begin
            errors++;
            $display("FAIL sweep_latency_1: got %0d expected 5", lb);
        end
        checks++;
        if (lc != 12) begin
            errors++;
            $display("FAIL sweep_latency_8: got %0d expected 12", lc);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        r0v = 1'b0; r1v = 1'b0; r0s = 1'b0; r1s = 1'b0;
        spec = 1'b0; rrdy = 1'b0;
        test_reset();
        test_single_op();
        test_special();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_param_sweep();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
